// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: boot hold, DMEM wait FSM with timeout, sticky fault; PIPE_CTRL_PERF_EN adds event counters.
// Latency: stall/flush controls are combinational from state and inputs (zero-cycle DMEM release); CtrlState/MemTimeout registered.
// Backpressure: a DMEM wait freezes every stage; an IMEM miss or load-use hazard holds only the front end.
module pipe_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lwStall,
    input  logic             PCSrcE,
    input  logic             IMemReady,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] PerfLwCnt,
    output logic [CNT_W-1:0] PerfBrCnt,
    output logic [CNT_W-1:0] PerfDmemCnt,
    output logic [CNT_W-1:0] PerfImemCnt,
`endif
    output logic [1:0]       CtrlState
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWAIT = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam logic [7:0]       BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [7:0]       boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic dwait;
    logic active;
    logic case_dmem, case_br, case_lw, case_imem;
    logic hold_all;

    assign dwait  = MemReqM & ~MemReadyM;
    assign active = ~rst & ((state_q == ST_RUN) | (state_q == ST_DWAIT));

    // One-hot priority decode: DMEM wait > branch redirect > load-use > IMEM miss.
    assign case_dmem = active & dwait;
    assign case_br   = active & ~dwait & PCSrcE;
    assign case_lw   = active & ~dwait & ~PCSrcE & lwStall;
    assign case_imem = active & ~dwait & ~PCSrcE & ~lwStall & ~IMemReady;

    // Reset, boot, fault and DMEM wait all freeze the whole pipe identically.
    assign hold_all = rst | (state_q == ST_BOOT) | (state_q == ST_FAULT) | case_dmem;

    assign StallF = hold_all | case_lw | case_imem;
    assign StallD = hold_all | case_lw;
    assign StallE = hold_all;
    assign StallM = hold_all;
    assign FlushW = hold_all;
    assign FlushD = case_br | case_imem;
    assign FlushE = case_br | case_lw;

    assign CtrlState  = state_q;
    assign MemTimeout = mem_timeout_q;

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (dwait) begin
                    state_d    = ST_DWAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_DWAIT: begin
                if (!dwait) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // The access has now waited MEM_TIMEOUT cycles.
                    state_d       = ST_FAULT;
                    mem_timeout_d = 1'b1;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                mem_timeout_d = 1'b1;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_lw_q, perf_lw_d;
    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_dmem_q, perf_dmem_d;
    logic [CNT_W-1:0] perf_imem_q, perf_imem_d;

    // Case flags are already gated to RUN/DWAIT; counters stick at all-ones.
    always_comb begin
        perf_lw_d   = perf_lw_q;
        perf_br_d   = perf_br_q;
        perf_dmem_d = perf_dmem_q;
        perf_imem_d = perf_imem_q;
        if (case_lw && perf_lw_q != CNT_MAX)     perf_lw_d   = perf_lw_q + CNT_W'(1);
        if (case_br && perf_br_q != CNT_MAX)     perf_br_d   = perf_br_q + CNT_W'(1);
        if (case_dmem && perf_dmem_q != CNT_MAX) perf_dmem_d = perf_dmem_q + CNT_W'(1);
        if (case_imem && perf_imem_q != CNT_MAX) perf_imem_d = perf_imem_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw_q   <= '0;
            perf_br_q   <= '0;
            perf_dmem_q <= '0;
            perf_imem_q <= '0;
        end else begin
            perf_lw_q   <= perf_lw_d;
            perf_br_q   <= perf_br_d;
            perf_dmem_q <= perf_dmem_d;
            perf_imem_q <= perf_imem_d;
        end
    end

    assign PerfLwCnt   = perf_lw_q;
    assign PerfBrCnt   = perf_br_q;
    assign PerfDmemCnt = perf_dmem_q;
    assign PerfImemCnt = perf_imem_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl with BOOT_CYCLES=4 and MEM_TIMEOUT=4.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, lwStall, PCSrcE, IMemReady, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0] CtrlState;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] PerfLwCnt, PerfBrCnt, PerfDmemCnt, PerfImemCnt;
`endif

    pipe_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .lwStall(lwStall), .PCSrcE(PCSrcE),
        .IMemReady(IMemReady), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
`ifdef PIPE_CTRL_PERF_EN
        .PerfLwCnt(PerfLwCnt), .PerfBrCnt(PerfBrCnt),
        .PerfDmemCnt(PerfDmemCnt), .PerfImemCnt(PerfImemCnt),
`endif
        .CtrlState(CtrlState)
    );

    // Expected word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW, MemTimeout, CtrlState[1:0]}
    localparam logic [6:0] HOLD = 7'b1111_001;
    localparam logic [6:0] NONE = 7'b0000_000;
    localparam logic [6:0] LW   = 7'b1100_010;
    localparam logic [6:0] BR   = 7'b0000_110;
    localparam logic [6:0] IMIS = 7'b1000_100;

    typedef struct {
        logic       r, lw, br, imr, req, rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int n_pass = 0;
    int n_chk  = 0;

    function automatic logic [9:0] outs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout, CtrlState};
    endfunction

    task automatic add(input logic r, lw, br, imr, req, rdy, input logic [6:0] ctl,
                       input logic mt, input logic [1:0] st);
        vec_t v;
        v.r = r; v.lw = lw; v.br = br; v.imr = imr; v.req = req; v.rdy = rdy;
        v.exp = {ctl, mt, st};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, lw, br, imr, req, rdy);
        rst = r; lwStall = lw; PCSrcE = br; IMemReady = imr; MemReqM = req; MemReadyM = rdy;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        n_chk++;
        if (outs() === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, outs(), exp);
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive one cycle's inputs, check just before the next edge's settle point, then advance.
    task automatic cyc(input string name, input logic r, lw, br, imr, req, rdy,
                       input logic [6:0] ctl, input logic mt, input logic [1:0] st);
        drive(r, lw, br, imr, req, rdy);
        #1;
        check(name, {ctl, mt, st});
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   r  lw br imr req rdy  ctl   mt  st
        add(1, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);  // 0 second reset cycle
        add(0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);  // 1 boot 1
        add(0, 0, 1, 1, 0, 0, HOLD, 0, 2'd0);  // 2 boot 2, branch ignored
        add(0, 0, 0, 0, 1, 0, HOLD, 0, 2'd0);  // 3 boot 3, mem inputs ignored
        add(0, 1, 0, 1, 0, 0, HOLD, 0, 2'd0);  // 4 boot 4, lwStall ignored
        add(0, 0, 0, 1, 0, 0, NONE, 0, 2'd1);  // 5 run idle
        add(0, 1, 0, 1, 0, 0, LW,   0, 2'd1);  // 6 load-use
        add(0, 1, 1, 1, 0, 0, BR,   0, 2'd1);  // 7 branch beats load-use
        add(0, 0, 1, 0, 0, 0, BR,   0, 2'd1);  // 8 branch beats imem miss
        add(0, 0, 0, 0, 0, 0, IMIS, 0, 2'd1);  // 9 imem miss 1
        add(0, 0, 0, 0, 0, 0, IMIS, 0, 2'd1);  // 10 imem miss 2
        add(0, 1, 0, 0, 0, 0, LW,   0, 2'd1);  // 11 load-use beats imem miss
        add(0, 0, 0, 1, 1, 1, NONE, 0, 2'd1);  // 12 single-cycle access
        add(0, 0, 0, 1, 1, 0, HOLD, 0, 2'd1);  // 13 wait 1
        add(0, 0, 1, 0, 1, 0, HOLD, 0, 2'd2);  // 14 wait 2, branch/imem ignored
        add(0, 1, 0, 1, 1, 0, HOLD, 0, 2'd2);  // 15 wait 3
        add(0, 0, 0, 1, 1, 1, NONE, 0, 2'd2);  // 16 zero-cycle release
        add(0, 0, 0, 1, 0, 0, NONE, 0, 2'd1);  // 17 back in run
        add(0, 0, 0, 1, 1, 0, HOLD, 0, 2'd1);  // 18 timeout wait 1
        add(0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);  // 19 wait 2
        add(0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);  // 20 wait 3
        add(0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);  // 21 wait 4 -> fault
        add(0, 0, 0, 1, 1, 0, HOLD, 1, 2'd3);  // 22 fault
        add(0, 0, 0, 1, 1, 1, HOLD, 1, 2'd3);  // 23 ready does not clear fault
        add(0, 1, 1, 0, 0, 0, HOLD, 1, 2'd3);  // 24 other inputs ignored
        add(1, 0, 0, 1, 0, 0, HOLD, 1, 2'd3);  // 25 reset asserted, state not yet updated
        add(0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);  // 26 boot after fault

        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].r, vecs[i].lw, vecs[i].br, vecs[i].imr,
                vecs[i].req, vecs[i].rdy, vecs[i].exp[9:3], vecs[i].exp[2], vecs[i].exp[1:0]);
        end

        // Finish boot, then abandon a DMEM wait with reset.
        cyc("boot2b", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        cyc("boot3b", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        cyc("boot4b", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        cyc("run_b",  0, 1, 0, 1, 0, 0, LW,   0, 2'd1);
        cyc("mw1",    0, 0, 0, 1, 1, 0, HOLD, 0, 2'd1);
        cyc("mw2",    0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);
        cyc("mw_rst", 1, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);
`ifdef PIPE_CTRL_PERF_EN
        drive(0, 0, 0, 1, 0, 0);
        #1;
        check_val("perf_lw_rst",   PerfLwCnt,   16'd0);
        check_val("perf_br_rst",   PerfBrCnt,   16'd0);
        check_val("perf_dmem_rst", PerfDmemCnt, 16'd0);
        check_val("perf_imem_rst", PerfImemCnt, 16'd0);
`endif
        cyc("post_rst1", 0, 0, 0, 1, 1, 0, HOLD, 0, 2'd0);
        cyc("post_rst2", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        cyc("post_rst3", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        cyc("post_rst4", 0, 0, 0, 1, 0, 0, HOLD, 0, 2'd0);
        // A fresh wait must run its full count again: the counter was cleared by reset.
        cyc("fresh_w1",  0, 0, 0, 1, 1, 0, HOLD, 0, 2'd1);
        cyc("fresh_w2",  0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);
        cyc("fresh_w3",  0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);
        cyc("fresh_w4",  0, 0, 0, 1, 1, 0, HOLD, 0, 2'd2);
        cyc("fresh_flt", 0, 0, 0, 1, 0, 0, HOLD, 1, 2'd3);
`ifdef PIPE_CTRL_PERF_EN
        check_val("perf_lw",   PerfLwCnt,   16'd0);
        check_val("perf_dmem", PerfDmemCnt, 16'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
